// File: rtl/matmul_sp_writer.sv
// rtl/matmul_sp_writer.sv - captures a packed C matrix and streams its valid
// elements into a scratchpad one beat at a time, keeping sticky overflow flags.
module matmul_sp_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int SP_SEL_W   = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         enable_w_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)**2*2*DATA_WIDTH-1:0] c_matrix_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)**2-1:0]         flags_i,
  input  logic [2:0]                                   n_dim_i,
  input  logic [2:0]                                   m_dim_i,
  input  logic [SP_SEL_W-1:0]                          sp_target_i,
  input  logic                                         clear_flags_i,
  input  logic                                         sp_ready_i,
  output logic                                         sp_wr_o,
  output logic [SP_SEL_W+((BUS_WIDTH/DATA_WIDTH)**2 > 1 ? $clog2((BUS_WIDTH/DATA_WIDTH)**2) : 1)-1:0] sp_addr_o,
  output logic [2*DATA_WIDTH-1:0]                      sp_wdata_o,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic                                         drop_o,
  output logic [(BUS_WIDTH/DATA_WIDTH)**2-1:0]         flags_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int NE      = MAX_DIM * MAX_DIM;
  localparam int EW      = 2 * DATA_WIDTH;
  localparam int IDX_W   = (NE > 1) ? $clog2(NE) : 1;
  localparam int CNT_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]          state_q;
  logic [NE*EW-1:0]    c_q;
  logic [SP_SEL_W-1:0] tgt_q;
  logic [CNT_W-1:0]    row_q, col_q, n_last_q, m_last_q;
  logic [NE-1:0]       flags_q;
  logic                drop_q;

  logic [2:0]          n_cl, m_cl;
  logic [NE-1:0]       mask;
  logic [NE-1:0]       flags_base;
  logic [IDX_W-1:0]    idx;
  logic                capture;

  always_comb begin
    n_cl = (int'(n_dim_i) > MAX_DIM) ? 3'(MAX_DIM) : n_dim_i;
    m_cl = (int'(m_dim_i) > MAX_DIM) ? 3'(MAX_DIM) : m_dim_i;
    mask = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      for (int j = 0; j < MAX_DIM; j++) begin
        mask[i*MAX_DIM+j] = (i < int'(n_cl)) && (j < int'(m_cl));
      end
    end
  end

  assign capture    = enable_w_i && (state_q == S_IDLE);
  assign flags_base = clear_flags_i ? '0 : flags_q;
  assign idx        = IDX_W'(int'(row_q) * MAX_DIM + int'(col_q));

  // Outputs decode straight from state so an async reset drops them at once.
  assign sp_wr_o    = (state_q == S_WRITE);
  assign busy_o     = (state_q == S_WRITE) || (state_q == S_DONE);
  assign done_o     = (state_q == S_DONE);
  assign drop_o     = drop_q;
  assign flags_o    = flags_q;
  assign sp_addr_o  = {tgt_q, idx};
  assign sp_wdata_o = c_q[int'(idx)*EW +: EW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      tgt_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      n_last_q <= '0;
      m_last_q <= '0;
      flags_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= enable_w_i && (state_q != S_IDLE);

      if (capture) begin
        flags_q <= flags_base | (flags_i & mask);
      end else if (clear_flags_i) begin
        flags_q <= '0;
      end

      case (state_q)
        S_IDLE: begin
          if (enable_w_i) begin
            c_q      <= c_matrix_i;
            tgt_q    <= sp_target_i;
            row_q    <= '0;
            col_q    <= '0;
            n_last_q <= CNT_W'(n_cl - 3'd1);
            m_last_q <= CNT_W'(m_cl - 3'd1);
            state_q  <= ((n_cl == 3'd0) || (m_cl == 3'd0)) ? S_DONE : S_WRITE;
          end
        end
        S_WRITE: begin
          if (sp_ready_i) begin
            if (col_q == m_last_q) begin
              col_q <= '0;
              if (row_q == n_last_q) begin
                state_q <= S_DONE;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sp_writer.sv
// tb/tb_matmul_sp_writer.sv - scoreboard bench for matmul_sp_writer.
module tb_matmul_sp_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_w;
  logic [63:0] c_matrix;
  logic [3:0]  flags_in;
  logic [2:0]  n_dim, m_dim;
  logic [1:0]  sp_target;
  logic        clear_flags;
  logic        sp_ready;
  logic        sp_wr;
  logic [3:0]  sp_addr;
  logic [15:0] sp_wdata;
  logic        busy, done, drop;
  logic [3:0]  flags_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [19:0] beat_q[$];
  int          done_q[$];

  matmul_sp_writer dut (
    .clk_i(clk), .rst_i(rst), .enable_w_i(enable_w), .c_matrix_i(c_matrix),
    .flags_i(flags_in), .n_dim_i(n_dim), .m_dim_i(m_dim), .sp_target_i(sp_target),
    .clear_flags_i(clear_flags), .sp_ready_i(sp_ready), .sp_wr_o(sp_wr),
    .sp_addr_o(sp_addr), .sp_wdata_o(sp_wdata), .busy_o(busy), .done_o(done),
    .drop_o(drop), .flags_o(flags_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_beat(input logic [3:0] a, input logic [15:0] d);
    beat_q.push_back({a, d});
  endtask

  // Monitor: every presented beat must match the queue head; it pops on accept.
  always @(negedge clk) begin
    if (!rst) begin
      if (sp_wr) begin
        if (beat_q.size() == 0) chk("unexpected_beat", {sp_addr, sp_wdata}, 64'h0);
        else begin
          chk("beat", {sp_addr, sp_wdata}, beat_q[0]);
          if (sp_ready) void'(beat_q.pop_front());
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", cyc, 0);
        else chk("done_cycle", cyc, done_q.pop_front());
        chk("done_busy", busy, 1);
        chk("done_no_wr", sp_wr, 0);
      end
    end
  end

  task automatic start(input logic [63:0] c, input logic [3:0] f, input logic [2:0] n,
                       input logic [2:0] m, input logic [1:0] tgt, input logic clr,
                       output int t0);
    @(posedge clk); #1;
    c_matrix = c; flags_in = f; n_dim = n; m_dim = m; sp_target = tgt;
    clear_flags = clr; enable_w = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    enable_w = 1'b0; clear_flags = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_idle_timeout"}, k >= 50, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int t0;
    rst = 1'b1; enable_w = 0; c_matrix = '0; flags_in = '0; n_dim = 0; m_dim = 0;
    sp_target = 0; clear_flags = 0; sp_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {sp_wr, busy, done, drop, flags_out, sp_addr, sp_wdata}, 0);
    rst = 1'b0;

    // 1: 2x2, ready held, target 1
    push_beat(4'd4, 16'h0004); push_beat(4'd5, 16'hFFFE);
    push_beat(4'd6, 16'h0010); push_beat(4'd7, 16'h8000);
    start({16'h8000, 16'h0010, 16'hFFFE, 16'h0004}, 4'b0000, 3'd2, 3'd2, 2'd1, 0, t0);
    done_q.push_back(t0 + 5);
    chk("t1_busy", busy, 1);
    wait_idle("t1");

    // 2: 2x1 with a ready stall, target 2
    push_beat(4'd8, 16'h1111); push_beat(4'd10, 16'h3333);
    start({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4'b1111, 3'd2, 3'd1, 2'd2, 0, t0);
    done_q.push_back(t0 + 4);
    chk("t2_flags", flags_out, 4'b0101);
    @(posedge clk); #1; sp_ready = 0;
    @(posedge clk); #1; sp_ready = 1;
    wait_idle("t2");

    // 3: n=0, no beats, flags untouched
    start(64'hDEAD_BEEF_0BAD_F00D, 4'b1111, 3'd0, 3'd2, 2'd0, 0, t0);
    done_q.push_back(t0 + 1);
    chk("t3_flags", flags_out, 4'b0101);
    wait_idle("t3");

    // 5: masked capture, then clear + capture in one cycle
    @(posedge clk); #1; clear_flags = 1;
    @(posedge clk); #1; clear_flags = 0;
    chk("t5_clear", flags_out, 4'b0000);
    push_beat(4'd0, 16'h0101); push_beat(4'd1, 16'h0202);
    start({16'h0404, 16'h0303, 16'h0202, 16'h0101}, 4'b1111, 3'd1, 3'd2, 2'd0, 0, t0);
    done_q.push_back(t0 + 3);
    chk("t5_mask", flags_out, 4'b0011);
    wait_idle("t5a");
    push_beat(4'd4, 16'hA001); push_beat(4'd5, 16'hA002);
    push_beat(4'd6, 16'hA003); push_beat(4'd7, 16'hA004);
    start({16'hA004, 16'hA003, 16'hA002, 16'hA001}, 4'b0001, 3'd2, 3'd2, 2'd1, 1, t0);
    done_q.push_back(t0 + 5);
    chk("t5_clr_cap", flags_out, 4'b0001);
    wait_idle("t5b");

    // 4: enable during WRITE is dropped; clamped dims (7 -> 2)
    push_beat(4'd12, 16'h00AA); push_beat(4'd13, 16'h00BB);
    push_beat(4'd14, 16'h00CC); push_beat(4'd15, 16'h00DD);
    start({16'h00DD, 16'h00CC, 16'h00BB, 16'h00AA}, 4'b0000, 3'd7, 3'd7, 2'd3, 0, t0);
    done_q.push_back(t0 + 5);
    @(posedge clk); #1;
    c_matrix = {4{16'hEEEE}}; flags_in = 4'b1111; sp_target = 0; enable_w = 1;
    @(posedge clk); #1; enable_w = 0;
    @(negedge clk); chk("t4_drop", drop, 1);
    chk("t4_flags", flags_out, 4'b0001);
    @(negedge clk); chk("t4_drop_pulse", drop, 0);
    #1;
    wait_idle("t4");

    // 6: async reset mid-WRITE after one beat
    push_beat(4'd8, 16'h0001);
    start({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 4'b1111, 3'd2, 3'd2, 2'd2, 0, t0);
    chk("t6_flags", flags_out, 4'b1111);
    @(posedge clk); #3; rst = 1;
    #1;
    chk("t6_rst_async", {sp_wr, busy, done, flags_out}, 0);
    @(posedge clk); #1; rst = 0;
    repeat (3) @(posedge clk);
    #1;
    push_beat(4'd4, 16'h7777);
    start({48'h0, 16'h7777}, 4'b0000, 3'd1, 3'd1, 2'd1, 0, t0);
    done_q.push_back(t0 + 2);
    wait_idle("t6");

    repeat (2) @(posedge clk);
    #1;
    chk("beats_left", beat_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
